board_scanout: RTL

Downstream consumer of the game core's 32-bit `board_out`: snapshots the 8-row × 4-column board and refreshes an external LED matrix one row at a time. Drives a 595-style column shift register (serial data/clock/latch) and a 3-bit row decoder. New boards are applied only at frame boundaries, so the display never tears.

---
 rtl/tetris_pkg.sv | 18 +
 rtl/row_serializer.sv | 82 ++++++++
 rtl/board_scanout.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the board display path.
//   ROWS / COLS : default board geometry (row r = board[4r+3:4r], row 0 on top)
//   BOARD_W     : width of the packed board word from the game core
//   scan_state_t: scan-out controller states
package tetris_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 4;
  localparam int BOARD_W = ROWS * COLS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/row_serializer.sv
// Shifts one COLS-bit row out to a 595-style shift register, MSB (highest
// column) first. Each bit occupies two cycles: ser_clk low then high, so data
// is set up a full cycle before the rising edge and held a full cycle after.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   start_i     : begin shifting row_i (sampled on the same edge as row_i)
//   row_i       : row bits, COLS wide
//   ser_data_o  : registered serial data
//   ser_clk_o   : registered shift clock
//   done_o      : high during the final phase of a row
module row_serializer #(
  parameter int COLS = tetris_pkg::COLS
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [COLS-1:0] row_i,
  output logic            ser_data_o,
  output logic            ser_clk_o,
  output logic            done_o
);

  localparam int PW = $clog2(2 * COLS);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * COLS - 1);

  logic [COLS-1:0] shreg_q, shreg_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic            active_q, active_d;
  logic            data_q, data_d;
  logic            clk_q, clk_d;

  assign done_o     = active_q && (ph_q == PH_LAST);
  assign ser_data_o = data_q;
  assign ser_clk_o  = clk_q;

  always_comb begin
    shreg_d  = shreg_q;
    ph_d     = ph_q;
    active_d = active_q;
    data_d   = data_q;
    clk_d    = clk_q;
    if (start_i) begin
      shreg_d  = row_i;
      ph_d     = '0;
      active_d = 1'b1;
      data_d   = row_i[COLS-1];
      clk_d    = 1'b0;
    end else if (active_q) begin
      if (done_o) begin
        ph_d     = '0;
        active_d = 1'b0;
        data_d   = 1'b0;
        clk_d    = 1'b0;
      end else begin
        ph_d  = ph_q + PW'(1);
        clk_d = ~ph_q[0];
        // Data only moves on the high->low transition of ser_clk.
        if (ph_q[0]) begin
          shreg_d = shreg_q << 1;
          data_d  = shreg_q[COLS-2];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q  <= '0;
      ph_q     <= '0;
      active_q <= 1'b0;
      data_q   <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      ph_q     <= ph_d;
      active_q <= active_d;
      data_q   <= data_d;
      clk_q    <= clk_d;
    end
  end

endmodule

// File: rtl/board_scanout.sv
// Snapshots the game board and continuously refreshes an LED matrix one row at
// a time: shift the row into a column shift register, latch it, then light the
// row for HOLD_CYCLES. New boards only take effect at frame boundaries.
//   in_clka     : clock
//   in_restart  : synchronous active-high reset
//   board_in    : packed board, board_valid marks a new one
//   ser_data / ser_clk / ser_latch : column shift-register interface
//   row_sel / row_en : row decoder index and enable
//   frame_done  : pulse on the last cycle of each frame
//   busy        : high whenever scanning
module board_scanout
  import tetris_pkg::scan_state_t, tetris_pkg::S_IDLE, tetris_pkg::S_SHIFT,
         tetris_pkg::S_LATCH, tetris_pkg::S_HOLD;
#(
  parameter int ROWS        = tetris_pkg::ROWS,
  parameter int COLS        = tetris_pkg::COLS,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                    in_clka,
  input  logic                    in_restart,
  input  logic [ROWS*COLS-1:0]    board_in,
  input  logic                    board_valid,
  output logic                    ser_data,
  output logic                    ser_clk,
  output logic                    ser_latch,
  output logic [$clog2(ROWS)-1:0] row_sel,
  output logic                    row_en,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int RW = $clog2(ROWS);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  scan_state_t            state_q, state_d;
  logic [ROWS*COLS-1:0]   snap_q, snap_d;
  logic [ROWS*COLS-1:0]   pend_q, pend_d;
  logic                   pend_v_q, pend_v_d;
  logic [RW-1:0]          row_q, row_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   ser_latch_q, row_en_q, frame_done_q, busy_q;
  logic [RW-1:0]          row_sel_q;
  logic                   ser_start;
  logic                   ser_done;

  // The serializer samples the row on the same edge the FSM enters SHIFT, so
  // it is fed from the next-state snapshot and row index.
  row_serializer #(.COLS(COLS)) u_ser (
    .clk_i      (in_clka),
    .rst_i      (in_restart),
    .start_i    (ser_start),
    .row_i      (snap_d[row_d*COLS +: COLS]),
    .ser_data_o (ser_data),
    .ser_clk_o  (ser_clk),
    .done_o     (ser_done)
  );

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    row_d     = row_q;
    hold_d    = hold_q;
    ser_start = 1'b0;

    // While scanning, a new board waits for the next frame; latest wins.
    if (state_q != S_IDLE && board_valid) begin
      pend_d   = board_in;
      pend_v_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (board_valid) begin
          snap_d    = board_in;
          row_d     = '0;
          state_d   = S_SHIFT;
          ser_start = 1'b1;
        end
      end
      S_SHIFT: begin
        if (ser_done) state_d = S_LATCH;
      end
      S_LATCH: begin
        hold_d  = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d   = S_SHIFT;
          ser_start = 1'b1;
          if (row_q != ROW_LAST) begin
            row_d = row_q + RW'(1);
          end else begin
            // Frame boundary: a board arriving right now beats the pending one.
            row_d = '0;
            if (board_valid) begin
              snap_d   = board_in;
              pend_v_d = 1'b0;
            end else if (pend_v_q) begin
              snap_d   = pend_q;
              pend_v_d = 1'b0;
            end
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      row_q        <= '0;
      hold_q       <= '0;
      ser_latch_q  <= 1'b0;
      row_sel_q    <= '0;
      row_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      ser_latch_q  <= (state_d == S_LATCH);
      if (state_d == S_LATCH) row_sel_q <= row_q;
      row_en_q     <= (state_d == S_HOLD);
      frame_done_q <= (state_d == S_HOLD) && (hold_d == HOLD_LAST) &&
                      (row_d == ROW_LAST);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign ser_latch  = ser_latch_q;
  assign row_sel    = row_sel_q;
  assign row_en     = row_en_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule
